conv_channel_sequencer: RTL and testbench
=========================================

# conv_channel_sequencer

Initiator side of the kernel-load handshake for one convolution layer. It walks output channels 0..OC-1. For each channel it presents the channel index and requests a kernel load with `c_load`, then waits for `c_load_done`. Once the kernel is loaded it launches the convolution engine, waits for that engine to complete, and releases the load request before advancing. It sits between the layer controller and the kernel loader / convolution datapath.

## Interface
- `OC`, default 8: number of output channels to sequence; range 1..16.
- `TMO_W`, default 8: watchdog counter width. Used only with `SEQ_TIMEOUT_EN`.

- `clk`  in  1: single clock; every flop is rising-edge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: layer start request; sampled in IDLE only.
- `busy`  out  1: high in every state except IDLE.
- `layer_done`  out  1: one-cycle pulse when the last channel has been released.
- `out_c`  out  4: current output-channel index; drives the loader's channel select.
- `c_load`  out  1: kernel-load request, level-held (4-phase).
- `c_load_done`  in  1: loader acknowledge; stays high while `c_load` is high.
- `conv_start`  out  1: one-cycle pulse that launches the convolution engine for `out_c`.
- `conv_done`  in  1: one-cycle pulse from the engine when the channel is finished.
- `err`  out  1: sticky watchdog error. Constant 0 without `SEQ_TIMEOUT_EN`.

## Operation
- States: IDLE, REQ, RUN, REL.
- **IDLE**
  - Transition: `start`=1 and `c_load_done`=0 → REQ, with `out_c`<=0 and `c_load`<=1.
  - `start` while `c_load_done`=1 (stale acknowledge) is ignored.
  - `err` is cleared on an accepted `start`.
- **REQ**
  - Holds `c_load`=1.
  - On `c_load_done`=1: go to RUN and issue `conv_start`=1 for exactly one cycle.
- **RUN**
  - Keeps `c_load`=1 so the loaded kernel stays stable.
  - On `conv_done`=1: set `c_load`<=0 and go to REL.
- **REL**
  - Waits for `c_load_done`=0.
  - If `out_c`==OC-1: pulse `layer_done`, return to IDLE.
  - Otherwise: `out_c`<=`out_c`+1, `c_load`<=1, go to REQ.
- `out_c` changes only in the REL→REQ and IDLE→REQ transitions. It never changes while `c_load` or `c_load_done` is high, because the loader derives its address combinationally from `out_c`.
- `out_c` holds its final value (OC-1) in IDLE after a layer completes. It resets to 0.
- Ignored inputs:
  - `conv_done` outside RUN.
  - `c_load_done` rising outside REQ.
  - `start` outside IDLE.
- Out-of-order inputs:
  - `conv_done` arriving in the same cycle as `conv_start` is not possible by contract. If it does occur, it is ignored (RUN only samples `conv_done` from the next cycle).
  - `c_load_done` dropping in RUN is a protocol violation. The block stays in RUN; the condition is flagged only by the bench assertion.

## Timing
- Reset values: `busy`=0, `layer_done`=0, `out_c`=0, `c_load`=0, `conv_start`=0, `err`=0, state=IDLE.
- Reset mid-operation returns all of the above immediately, asynchronously. No partial channel is resumed.
- Latencies:
  - `start` sampled at edge N → `c_load`=1 and `busy`=1 after edge N.
  - `c_load_done` seen at edge M → `conv_start` high for the cycle after edge M.
  - `conv_done` at edge K → `c_load`=0 after edge K.
  - `c_load_done` low seen at edge L → next `c_load`=1, or `layer_done`, after edge L.
- With a loader that acknowledges in 1 cycle, overhead is 4 cycles per channel plus engine time.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- Macro: `SEQ_TIMEOUT_EN`.
- **Defined:**
  - A `TMO_W`-bit watchdog clears on every state change and counts every cycle spent in REQ or REL.
  - At all-ones it sets `err`=1, drops `c_load`, and returns to IDLE without `layer_done`.
  - `err` stays set until the next accepted `start` or reset.
- **Undefined:** no counter; REQ and REL wait indefinitely; `err` is tied to 0.

## Structure
- Shared package `conv_pkg`:
  - state enum `seq_state_t` {IDLE, REQ, RUN, REL};
  - channel-index width constant `CH_W`=4;
  - per-layer OC constants (layer 1 = 8 channels, layer 2 = 16 channels).
- One sub-module, `seq_watchdog`, holding the counter and its expiry flag. It is instantiated only under `SEQ_TIMEOUT_EN`.

## Test plan
- OC=3, loader that acknowledges in 1 cycle, engine that reports done after 5 cycles:
  - three `conv_start` pulses, with `out_c`=0,1,2 respectively;
  - `layer_done` exactly once, 1 cycle after the final release;
  - `busy` falls together with that `layer_done` pulse.
- `out_c` never changes while `c_load`|`c_load_done` is high. Run with a loader whose acknowledge delay is randomized over 1..4 cycles and the full OC=8 sequence.
- `start` re-asserted during RUN and a spurious `conv_done` in REQ → both ignored; the channel count is still exactly OC.
- `rst` pulled low in RUN of channel 2 → all outputs reach reset values immediately; a subsequent `start` restarts at `out_c`=0.
- `SEQ_TIMEOUT_EN` with `TMO_W`=4 and a loader that never acknowledges:
  - `err`=1 and `c_load`=0 after 15 cycles in REQ;
  - no `layer_done`;
  - the next `start` clears `err`.
- `start` issued while `c_load_done` is stuck high → stays in IDLE with `busy`=0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution-layer control blocks.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RUN  = 2'd2,
    REL  = 2'd3
  } seq_state_t;

  localparam int CH_W      = 4;
  localparam int OC_LAYER1 = 8;
  localparam int OC_LAYER2 = 16;

endpackage

// File: rtl/seq_watchdog.sv
// Wait-state watchdog for the channel sequencer: counts cycles while enabled,
// restarts on every state change and flags expiry on the step into all-ones.
module seq_watchdog #(
  parameter int TMO_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expire
);

  logic [TMO_W-1:0] r_cnt;
  logic [TMO_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_count) r_cnt <= w_cnt_inc;
  end

  // Expires in the cycle whose count step would land on all-ones.
  assign o_expire = i_count && (w_cnt_inc == {TMO_W{1'b1}});

endmodule

// File: rtl/conv_channel_sequencer.sv
// Kernel-load / convolution-launch sequencer over output channels 0..OC-1.
// Optional watchdog on the REQ/REL waits is enabled with SEQ_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for start (ignored while the loader still acknowledges)
// REQ   | c_load held, waiting for c_load_done
// RUN   | kernel loaded, engine launched, waiting for conv_done
// REL   | c_load dropped, waiting for c_load_done to fall
module conv_channel_sequencer
  import conv_pkg::*;
#(
  parameter int OC    = 8,
  parameter int TMO_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            layer_done,
  output logic [CH_W-1:0] out_c,
  output logic            c_load,
  input  logic            c_load_done,
  output logic            conv_start,
  input  logic            conv_done,
  output logic            err
);

  seq_state_t      r_state, w_state_nxt;
  logic [CH_W-1:0] r_out_c, w_out_c_nxt;
  logic            r_c_load, w_c_load_nxt;
  logic            r_conv_start, w_conv_start_nxt;
  logic            r_layer_done, w_layer_done_nxt;
  logic            r_busy;
  logic            r_err, w_err_nxt;
  logic            w_expire;
  logic            w_last;
  logic            w_done_ok;

  assign w_last    = (r_out_c == CH_W'(OC - 1));
  // The first RUN cycle is the conv_start cycle; a done there is not real.
  assign w_done_ok = conv_done && !r_conv_start;

`ifdef SEQ_TIMEOUT_EN
  seq_watchdog #(.TMO_W(TMO_W)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_state_nxt != r_state),
    .i_count  ((r_state == REQ) || (r_state == REL)),
    .o_expire (w_expire)
  );
`else
  logic [TMO_W-1:0] w_unused_tmo;
  assign w_unused_tmo = '0;
  assign w_expire     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_out_c      <= '0;
      r_c_load     <= 1'b0;
      r_conv_start <= 1'b0;
      r_layer_done <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_out_c      <= w_out_c_nxt;
      r_c_load     <= w_c_load_nxt;
      r_conv_start <= w_conv_start_nxt;
      r_layer_done <= w_layer_done_nxt;
      r_busy       <= (w_state_nxt != IDLE);
      r_err        <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (start && !c_load_done) w_state_nxt = REQ;
      REQ: begin
        if (c_load_done)   w_state_nxt = RUN;
        else if (w_expire) w_state_nxt = IDLE;
      end
      RUN: if (w_done_ok) w_state_nxt = REL;
      REL: begin
        if (!c_load_done)  w_state_nxt = w_last ? IDLE : REQ;
        else if (w_expire) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_out_c_nxt      = r_out_c;
    w_c_load_nxt     = r_c_load;
    w_conv_start_nxt = 1'b0;
    w_layer_done_nxt = 1'b0;
    w_err_nxt        = r_err;
    case (r_state)
      IDLE: begin
        if (start && !c_load_done) begin
          w_out_c_nxt  = '0;
          w_c_load_nxt = 1'b1;
          w_err_nxt    = 1'b0;
        end
      end
      REQ: begin
        if (c_load_done) begin
          w_conv_start_nxt = 1'b1;
        end else if (w_expire) begin
          w_c_load_nxt = 1'b0;
          w_err_nxt    = 1'b1;
        end
      end
      RUN: if (w_done_ok) w_c_load_nxt = 1'b0;
      REL: begin
        if (!c_load_done) begin
          if (w_last) begin
            w_layer_done_nxt = 1'b1;
          end else begin
            w_out_c_nxt  = r_out_c + 1'b1;
            w_c_load_nxt = 1'b1;
          end
        end else if (w_expire) begin
          w_err_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy       = r_busy;
  assign layer_done = r_layer_done;
  assign out_c      = r_out_c;
  assign c_load     = r_c_load;
  assign conv_start = r_conv_start;
  assign err        = r_err;

endmodule

// File: tb/tb_conv_channel_sequencer.sv
// Scoreboard bench: unit 0 is OC=3 with a 1-cycle loader and 5-cycle engine,
// unit 1 is OC=8 with randomized loader/engine delays.
module tb_conv_channel_sequencer;

  localparam int OC_A = 3;
  localparam int OC_B = 8;
  localparam int TMO  = 4;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] start, busy, layer_done, c_load, c_load_done, conv_start, conv_done, err;
  logic [1:0][3:0] out_c;

  logic [1:0] ack, eng_done, spur;
  int ld_mode [2];
  int ld_cnt  [2];
  int ld_dly  [2];
  int eng_cnt [2];

  int exp_q [2][$];
  int done_seen [2];
  logic [3:0] prev_oc [2];
  logic [1:0] prev_cl, prev_ack, prev_bz;
  int mon_exp;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  conv_channel_sequencer #(.OC(OC_A), .TMO_W(TMO)) u_a (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .layer_done(layer_done[0]),
    .out_c(out_c[0]), .c_load(c_load[0]), .c_load_done(c_load_done[0]),
    .conv_start(conv_start[0]), .conv_done(conv_done[0]), .err(err[0]));

  conv_channel_sequencer #(.OC(OC_B), .TMO_W(TMO)) u_b (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .layer_done(layer_done[1]),
    .out_c(out_c[1]), .c_load(c_load[1]), .c_load_done(c_load_done[1]),
    .conv_start(conv_start[1]), .conv_done(conv_done[1]), .err(err[1]));

  // ld_mode: 0 normal 4-phase loader, 1 never acknowledges, 2 acknowledge stuck high
  assign c_load_done[0] = (ld_mode[0] == 2) ? 1'b1 : (ld_mode[0] == 1) ? 1'b0 : ack[0];
  assign c_load_done[1] = (ld_mode[1] == 2) ? 1'b1 : (ld_mode[1] == 1) ? 1'b0 : ack[1];
  assign conv_done = eng_done | spur;

  // Loader follows c_load after ld_dly cycles; engine finishes a fixed/random time after conv_start.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack      <= '0;
      eng_done <= '0;
      for (int i = 0; i < 2; i++) begin
        ld_cnt[i]  <= 0;
        ld_dly[i]  <= 1;
        eng_cnt[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ld_mode[i] != 0) begin
          ack[i]    <= 1'b0;
          ld_cnt[i] <= 0;
        end else if (c_load[i] != ack[i]) begin
          if (ld_cnt[i] >= ld_dly[i] - 1) begin
            ack[i]    <= c_load[i];
            ld_cnt[i] <= 0;
            ld_dly[i] <= (i == 1) ? int'($urandom_range(1, 4)) : 1;
          end else begin
            ld_cnt[i] <= ld_cnt[i] + 1;
          end
        end else begin
          ld_cnt[i] <= 0;
        end
        if (conv_start[i])     eng_cnt[i] <= (i == 1) ? int'($urandom_range(1, 5)) : 4;
        else if (eng_cnt[i] > 0) eng_cnt[i] <= eng_cnt[i] - 1;
        eng_done[i] <= !conv_start[i] && (eng_cnt[i] == 1);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
    n_cmp++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        if (conv_start[i]) begin
          chk($sformatf("conv_start_expected_u%0d", i), exp_q[i].size() > 0, 1);
          if (exp_q[i].size() > 0) begin
            mon_exp = exp_q[i].pop_front();
            chk($sformatf("conv_start_out_c_u%0d", i), out_c[i], mon_exp);
          end
        end
        if (layer_done[i]) begin
          done_seen[i]++;
          chk($sformatf("layer_done_pending_ch_u%0d", i), exp_q[i].size(), 0);
          chk($sformatf("layer_done_busy_fall_u%0d", i), {busy[i], prev_bz[i]}, 2'b01);
          chk($sformatf("layer_done_after_release_u%0d", i), {prev_cl[i], prev_ack[i], c_load[i]}, 0);
        end
        if (out_c[i] != prev_oc[i])
          chk($sformatf("out_c_moved_under_load_u%0d", i), prev_cl[i] | prev_ack[i], 0);
      end
      prev_oc[i]  = out_c[i];
      prev_cl[i]  = c_load[i];
      prev_ack[i] = c_load_done[i];
      prev_bz[i]  = busy[i];
    end
  end

  // Reference: an accepted layer start yields conv_start for channels 0..OC-1 in order, then one layer_done.
  task automatic issue_layer(input int i);
    for (int c = 0; c < ((i == 0) ? OC_A : OC_B); c++) exp_q[i].push_back(c);
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int base;
    int t;
    base = done_seen[i];
    t = 0;
    while (done_seen[i] == base && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk($sformatf("layer_done_count_u%0d", i), done_seen[i] - base, 1);
    chk($sformatf("channels_left_u%0d", i), exp_q[i].size(), 0);
  endtask

  task automatic check_reset_vals(input int i);
    chk($sformatf("rst_busy_u%0d", i), busy[i], 0);
    chk($sformatf("rst_layer_done_u%0d", i), layer_done[i], 0);
    chk($sformatf("rst_out_c_u%0d", i), out_c[i], 0);
    chk($sformatf("rst_c_load_u%0d", i), c_load[i], 0);
    chk($sformatf("rst_conv_start_u%0d", i), conv_start[i], 0);
    chk($sformatf("rst_err_u%0d", i), err[i], 0);
  endtask

  initial begin
    int t;
    int base;
    rst = 1'b0;
    start = '0;
    spur = '0;
    ld_mode[0] = 0;
    ld_mode[1] = 0;
    done_seen[0] = 0;
    done_seen[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals(0);
    check_reset_vals(1);
    rst = 1'b1;
    @(posedge clk); #1;

    // OC=3 directed layer, start latency, final index held
    issue_layer(0);
    chk("start_c_load", c_load[0], 1);
    chk("start_busy", busy[0], 1);
    wait_done(0, 300);
    chk("idle_out_c_hold", out_c[0], OC_A - 1);
    chk("idle_busy", busy[0], 0);

    // OC=8 layers with random loader and engine timing
    for (int l = 0; l < 3; l++) begin
      issue_layer(1);
      wait_done(1, 3000);
    end

    // start during RUN and spurious conv_done in REQ are ignored
    issue_layer(0);
    t = 0;
    while (!conv_start[0] && t < 50) begin @(posedge clk); #1; t++; end
    chk("reach_run_ch0", conv_start[0], 1);
    start[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start[0] = 1'b0;
    t = 0;
    while (!(c_load[0] && out_c[0] == 1 && !c_load_done[0]) && t < 50) begin @(posedge clk); #1; t++; end
    chk("reach_req_ch1", {c_load[0], out_c[0]}, {1'b1, 4'd1});
    spur[0] = 1'b1;
    @(posedge clk); #1;
    spur[0] = 1'b0;
    wait_done(0, 300);

    // reset asserted in RUN of channel 2, then a clean restart
    issue_layer(1);
    t = 0;
    while (!(conv_start[1] && out_c[1] == 2) && t < 500) begin @(posedge clk); #1; t++; end
    chk("reach_run_ch2", {conv_start[1], out_c[1]}, {1'b1, 4'd2});
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals(1);
    exp_q[0].delete();
    exp_q[1].delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    issue_layer(1);
    chk("restart_out_c", out_c[1], 0);
    wait_done(1, 3000);

    // stale acknowledge blocks start
    ld_mode[0] = 2;
    @(posedge clk); #1;
    base = done_seen[0];
    start[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start[0] = 1'b0;
    chk("stale_ack_busy", busy[0], 0);
    chk("stale_ack_c_load", c_load[0], 0);
    ld_mode[0] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("stale_ack_no_done", done_seen[0] - base, 0);

`ifdef SEQ_TIMEOUT_EN
    // loader never acknowledges: 15 cycles in REQ, then err and abort
    ld_mode[0] = 1;
    base = done_seen[0];
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    chk("tmo_c_load_start", c_load[0], 1);
    repeat (14) @(posedge clk);
    #1;
    chk("tmo_c_load_cycle15", c_load[0], 1);
    chk("tmo_err_cycle15", err[0], 0);
    @(posedge clk); #1;
    chk("tmo_err_set", err[0], 1);
    chk("tmo_c_load_drop", c_load[0], 0);
    chk("tmo_busy_drop", busy[0], 0);
    repeat (5) @(posedge clk);
    #1;
    chk("tmo_err_sticky", err[0], 1);
    chk("tmo_no_layer_done", done_seen[0] - base, 0);
    ld_mode[0] = 0;
    repeat (2) @(posedge clk);
    #1;
    issue_layer(0);
    chk("tmo_err_cleared", err[0], 0);
    wait_done(0, 300);
`else
    chk("err_tied_u0", err[0], 0);
    chk("err_tied_u1", err[1], 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    n_bad++;
    $display("FAIL global_timeout: got t=%0t expected bench completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "bench did not complete");
  end

endmodule
